sensor_uart_scheduler: RTL and testbench

Shares the single 56-bit UART TX path between two sensor sources: filtered ADS1292 ECG samples and MPR121 touch status. It captures each source into a one-entry holding buffer and arbitrates round-robin between them. Each granted frame is packed with SOF, type, sequence number, overrun count and XOR checksum. It sits between sensor_core's source signals and uart_controller's TX valid/ready port, in the 25 MHz domain.

---
 rtl/sensor_uart_pkg.sv | 35 +++
 rtl/sensor_uart_scheduler_if.sv | 15 +
 rtl/uart_frame_pack.sv | 28 ++
 rtl/sensor_uart_scheduler.sv | 172 +++++++++++++++++
 tb/tb_sensor_uart_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_uart_pkg.sv
// rtl/sensor_uart_pkg.sv - shared constants, frame layout and FSM states for the sensor UART scheduler
// Contents: SOF default, frame type codes, frame field bit positions, scheduler state enum,
//           checksum helper over the five header/payload bytes plus the overrun byte.
package sensor_uart_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   localparam logic [3:0] TYPE_ECG   = 4'h1;
   localparam logic [3:0] TYPE_TOUCH = 4'h2;

   localparam int FRAME_W     = 56;
   localparam int SOF_LSB     = 48;
   localparam int TYPE_LSB    = 44;
   localparam int SEQ_LSB     = 40;
   localparam int PAYLOAD_LSB = 16;
   localparam int OVR_LSB     = 8;
   localparam int CSUM_LSB    = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEND  = 2'd2
   } state_t;

   // XOR of the six bytes that precede the checksum byte.
   function automatic logic [7:0] frame_checksum(input logic [FRAME_W-9:0] body);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 6; i++) begin
         acc = acc ^ body[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/sensor_uart_scheduler_if.sv
// rtl/sensor_uart_scheduler_if.sv - valid/ready frame stream towards uart_controller
// Signals: tx_data (56-bit frame), tx_valid (frame valid), tx_ready (consumer ready).
// Modports: master drives data/valid, slave drives ready.
interface sensor_uart_scheduler_if
   import sensor_uart_pkg::*;
   ();

   logic [FRAME_W-1:0] tx_data;
   logic               tx_valid;
   logic               tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_frame_pack.sv
// rtl/uart_frame_pack.sv - combinational 56-bit frame builder with XOR checksum
// Ports: frame_type (4), seq (4), payload (24), overrun (8) in; frame (56) out.
module uart_frame_pack
   import sensor_uart_pkg::*;
#(
   parameter logic [7:0] P_SOF = SOF_DEFAULT
) (
   input  logic [3:0]         frame_type,
   input  logic [3:0]         seq,
   input  logic [23:0]        payload,
   input  logic [7:0]         overrun,
   output logic [FRAME_W-1:0] frame
);

   logic [FRAME_W-1:0] body;

   always_comb begin
      body = '0;
      body[SOF_LSB +: 8]      = P_SOF;
      body[TYPE_LSB +: 4]     = frame_type;
      body[SEQ_LSB +: 4]      = seq;
      body[PAYLOAD_LSB +: 24] = payload;
      body[OVR_LSB +: 8]      = overrun;
   end

   assign frame = {body[FRAME_W-1:8], frame_checksum(body[FRAME_W-1:8])};

endmodule

// File: rtl/sensor_uart_scheduler.sv
// rtl/sensor_uart_scheduler.sv - round-robin scheduler sharing the UART TX path between ECG and touch frames
// Ports: i_CLK/i_RSTN clock and async active-low reset; i_RUN streaming enable;
//        i_ECG_DATA/i_ECG_VALID/o_ECG_ACK ECG sample capture; i_TOUCH_STATUS touch level input;
//        tx frame stream (master); o_ECG_OVERRUN_CNT saturating discard count; o_BUSY activity flag.
module sensor_uart_scheduler
   import sensor_uart_pkg::*;
#(
   parameter int         P_HEARTBEAT_CYCLES = 2500000,
   parameter logic [7:0] P_SOF              = SOF_DEFAULT
) (
   input  logic                     i_CLK,
   input  logic                     i_RSTN,
   input  logic                     i_RUN,
   input  logic [23:0]              i_ECG_DATA,
   input  logic                     i_ECG_VALID,
   output logic                     o_ECG_ACK,
   input  logic [11:0]              i_TOUCH_STATUS,
   sensor_uart_scheduler_if.master  tx,
   output logic [7:0]               o_ECG_OVERRUN_CNT,
   output logic                     o_BUSY
);

   localparam int              HB_W    = $clog2(P_HEARTBEAT_CYCLES);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(P_HEARTBEAT_CYCLES - 1);

   state_t             state, state_nxt;
   logic               prev_valid;
   logic               rise;
   logic               ack_q;
   logic               ecg_pend;
   logic [23:0]        ecg_buf;
   logic               touch_pend;
   logic [11:0]        last_touch;
   logic [HB_W-1:0]    hb_cnt;
   logic               hb_hit;
   logic               touch_req;
   logic               rr_touch;     // 1: touch wins the next tie, 0: ECG wins
   logic [3:0]         seq;
   logic [7:0]         ovr_cnt;
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_nxt;
   logic               grant_ecg;
   logic               grant_touch;
   logic               handshake;
   logic [3:0]         pack_type;
   logic [23:0]        pack_payload;

   assign rise      = i_ECG_VALID & ~prev_valid;
   assign hb_hit    = (hb_cnt == HB_LAST);
   assign touch_req = i_RUN & ((i_TOUCH_STATUS != last_touch) | hb_hit);
   assign handshake = (state == SEND) & tx.tx_ready;

   // Touch payload is sampled here, at grant time, so status changes while
   // pending collapse into a single frame.
   assign pack_type    = grant_touch ? TYPE_TOUCH : TYPE_ECG;
   assign pack_payload = grant_touch ? {12'h000, i_TOUCH_STATUS} : ecg_buf;

   uart_frame_pack #(
      .P_SOF (P_SOF)
   ) u_pack (
      .frame_type (pack_type),
      .seq        (seq),
      .payload    (pack_payload),
      .overrun    (ovr_cnt),
      .frame      (frame_nxt)
   );

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_ecg   = 1'b0;
      grant_touch = 1'b0;
      case (state)
         IDLE: begin
            if (ecg_pend || touch_pend) begin
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (ecg_pend && touch_pend) begin
               grant_touch = rr_touch;
               grant_ecg   = ~rr_touch;
            end else begin
               grant_touch = touch_pend;
               grant_ecg   = ecg_pend;
            end
            state_nxt = SEND;
         end
         SEND: begin
            if (handshake) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         prev_valid <= 1'b0;
         ack_q      <= 1'b0;
         ecg_pend   <= 1'b0;
         ecg_buf    <= '0;
         touch_pend <= 1'b0;
         last_touch <= 12'h000;
         hb_cnt     <= '0;
         rr_touch   <= 1'b0;
         seq        <= 4'd0;
         ovr_cnt    <= 8'd0;
         frame_q    <= '0;
      end else begin
         prev_valid <= i_ECG_VALID;
         ack_q      <= rise;

         // A rise while the buffer is still full (including the grant cycle
         // that frees it) is discarded; only counted while running.
         if (rise && i_RUN) begin
            if (ecg_pend) begin
               if (ovr_cnt != 8'hFF) begin
                  ovr_cnt <= ovr_cnt + 8'd1;
               end
            end else begin
               ecg_buf  <= i_ECG_DATA;
               ecg_pend <= 1'b1;
            end
         end
         if (grant_ecg) begin
            ecg_pend <= 1'b0;
         end

         // Grant wins over a request in the same cycle: the request was
         // raised against the old last_touch, which the grant replaces.
         if (grant_touch) begin
            touch_pend <= 1'b0;
         end else if (touch_req) begin
            touch_pend <= 1'b1;
         end

         if (!i_RUN || hb_hit || grant_touch) begin
            hb_cnt <= '0;
         end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
         end

         if (grant_ecg || grant_touch) begin
            frame_q  <= frame_nxt;
            rr_touch <= grant_ecg;
         end
         if (grant_touch) begin
            last_touch <= i_TOUCH_STATUS;
         end

         if (handshake) begin
            seq <= seq + 4'd1;
         end
      end
   end

   assign tx.tx_valid       = (state == SEND);
   assign tx.tx_data        = frame_q;
   assign o_ECG_ACK         = ack_q;
   assign o_ECG_OVERRUN_CNT = ovr_cnt;
   assign o_BUSY            = (state != IDLE) | ecg_pend | touch_pend;

endmodule

// File: tb/tb_sensor_uart_scheduler.sv
// tb/tb_sensor_uart_scheduler.sv - directed self-checking bench for sensor_uart_scheduler
module tb_sensor_uart_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        run, ecg_valid, ecg_ack, busy;
   logic [23:0] ecg_data;
   logic [11:0] touch_status;
   logic [7:0]  ovr_cnt;

   logic        run_h, ecg_valid_h, ecg_ack_h, busy_h;
   logic [23:0] ecg_data_h;
   logic [11:0] touch_status_h;
   logic [7:0]  ovr_cnt_h;

   sensor_uart_scheduler_if tx_bus ();
   sensor_uart_scheduler_if hb_bus ();

   int vectors = 0;
   int miscompares = 0;

   sensor_uart_scheduler dut (
      .i_CLK (clk), .i_RSTN (rst_n), .i_RUN (run),
      .i_ECG_DATA (ecg_data), .i_ECG_VALID (ecg_valid), .o_ECG_ACK (ecg_ack),
      .i_TOUCH_STATUS (touch_status), .tx (tx_bus),
      .o_ECG_OVERRUN_CNT (ovr_cnt), .o_BUSY (busy)
   );

   sensor_uart_scheduler #(.P_HEARTBEAT_CYCLES (8)) dut_hb (
      .i_CLK (clk), .i_RSTN (rst_n), .i_RUN (run_h),
      .i_ECG_DATA (ecg_data_h), .i_ECG_VALID (ecg_valid_h), .o_ECG_ACK (ecg_ack_h),
      .i_TOUCH_STATUS (touch_status_h), .tx (hb_bus),
      .o_ECG_OVERRUN_CNT (ovr_cnt_h), .o_BUSY (busy_h)
   );

   function automatic logic [55:0] mk(input logic [3:0] t, input logic [3:0] s,
                                      input logic [23:0] p, input logic [7:0] o);
      logic [47:0] b;
      logic [7:0]  c;
      b = {8'hA5, t, s, p, o};
      c = b[47:40] ^ b[39:32] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
      return {b, c};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (tx_bus.tx_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic take_frame(output logic [55:0] d, output bit ok);
      wait_valid(ok);
      d = tx_bus.tx_data;
      tx_bus.tx_ready = 1'b1;
      step(1);
      tx_bus.tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; ecg_valid = 1'b0; ecg_data = '0; touch_status = '0;
      run_h = 1'b0; ecg_valid_h = 1'b0; ecg_data_h = '0; touch_status_h = '0;
      tx_bus.tx_ready = 1'b0; hb_bus.tx_ready = 1'b1;
      step(2);
      vectors++; if (tx_bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", tx_bus.tx_valid); end
      vectors++; if (tx_bus.tx_data !== 56'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", tx_bus.tx_data); end
      vectors++; if ({ecg_ack, busy, ovr_cnt} !== 10'h0) begin miscompares++; $display("FAIL reset_outs: got ack=%b busy=%b ovr=%h expected 0", ecg_ack, busy, ovr_cnt); end
      vectors++; if (hb_bus.tx_valid !== 1'b0 || busy_h !== 1'b0) begin miscompares++; $display("FAIL reset_hb: got valid=%b busy=%b expected 0", hb_bus.tx_valid, busy_h); end
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_ecg_frame();
      run = 1'b1; ecg_data = 24'h123456; ecg_valid = 1'b1;
      step(1);
      vectors++; if (ecg_ack !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL ecg_ack_busy: got ack=%b busy=%b expected 1 1", ecg_ack, busy); end
      ecg_valid = 1'b0;
      step(1);
      vectors++; if (ecg_ack !== 1'b0 || tx_bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL ecg_ack_width: got ack=%b valid=%b expected 0 0", ecg_ack, tx_bus.tx_valid); end
      step(1);
      vectors++; if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== 56'hA5_10_123456_00_C5) begin miscompares++; $display("FAIL ecg_frame: got valid=%b data=%h expected 1 a510123456_00c5", tx_bus.tx_valid, tx_bus.tx_data); end
      step(3);
      vectors++; if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== 56'hA5_10_123456_00_C5) begin miscompares++; $display("FAIL ecg_hold: got valid=%b data=%h expected held frame", tx_bus.tx_valid, tx_bus.tx_data); end
      tx_bus.tx_ready = 1'b1;
      step(1);
      tx_bus.tx_ready = 1'b0;
      vectors++; if (tx_bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL ecg_release: got valid=%b expected 0", tx_bus.tx_valid); end
   endtask

   task automatic test_touch_frame();
      logic [55:0] d;
      bit ok;
      touch_status = 12'h005;
      take_frame(d, ok);
      vectors++; if (!ok || d !== 56'hA5_21_000005_00_81) begin miscompares++; $display("FAIL touch_frame: got ok=%b data=%h expected a5210000050081", ok, d); end
      step(2);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL touch_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_overrun();
      logic [55:0] d;
      bit ok;
      ecg_data = 24'hABCDEF; ecg_valid = 1'b1; step(1); ecg_valid = 1'b0; step(3);
      ecg_data = 24'h111111; ecg_valid = 1'b1; step(1); ecg_valid = 1'b0; step(3);
      ecg_data = 24'h222222; ecg_valid = 1'b1; step(1);
      vectors++; if (ecg_ack !== 1'b1) begin miscompares++; $display("FAIL discard_ack: got %b expected 1", ecg_ack); end
      ecg_valid = 1'b0; step(1);
      vectors++; if (ovr_cnt !== 8'h01) begin miscompares++; $display("FAIL overrun_count: got %h expected 01", ovr_cnt); end
      take_frame(d, ok);
      vectors++; if (!ok || d !== 56'hA5_12_ABCDEF_00_3E) begin miscompares++; $display("FAIL overrun_frame1: got ok=%b data=%h expected a512abcdef003e", ok, d); end
      take_frame(d, ok);
      vectors++; if (!ok || d !== 56'hA5_13_111111_01_A6) begin miscompares++; $display("FAIL overrun_frame2: got ok=%b data=%h expected a513111111_01a6", ok, d); end
   endtask

   task automatic test_round_robin();
      logic [55:0] d, exp;
      bit ok;
      rst_n = 1'b0; step(1);
      touch_status = 12'h101; ecg_data = 24'hC00000; ecg_valid = 1'b1; rst_n = 1'b1;
      step(1);
      ecg_valid = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wait_valid(ok);
         if (i % 2 == 0) exp = mk(4'h1, 4'(i), 24'hC00000 | 24'(i), 8'h00);
         else            exp = mk(4'h2, 4'(i), {12'h000, 12'h100 | 12'(i)}, 8'h00);
         vectors++; if (!ok || tx_bus.tx_data !== exp) begin miscompares++; $display("FAIL rr_frame%0d: got ok=%b data=%h expected %h", i, ok, tx_bus.tx_data, exp); end
         if (i < 16) begin
            if (i % 2 == 0) begin
               ecg_data = 24'hC00000 | 24'(i + 2); ecg_valid = 1'b1; step(1); ecg_valid = 1'b0; step(1);
            end else begin
               touch_status = 12'h100 | 12'(i + 2); step(1);
            end
         end
         tx_bus.tx_ready = 1'b1; step(1); tx_bus.tx_ready = 1'b0;
      end
      take_frame(d, ok);
      exp = mk(4'h2, 4'h1, 24'h000111, 8'h00);
      vectors++; if (!ok || d !== exp) begin miscompares++; $display("FAIL rr_drain: got ok=%b data=%h expected %h", ok, d, exp); end
   endtask

   task automatic test_heartbeat();
      int c;
      run_h = 1'b1;
      c = 0;
      while (hb_bus.tx_valid !== 1'b1 && c < 40) begin step(1); c++; end
      vectors++; if (c != 10 || hb_bus.tx_data !== 56'hA5_20_000000_00_85) begin miscompares++; $display("FAIL hb_first: got cycles=%0d data=%h expected 10 a5200000000085", c, hb_bus.tx_data); end
      c = 0;
      while (hb_bus.tx_valid === 1'b1 && c < 40) begin step(1); c++; end
      while (hb_bus.tx_valid !== 1'b1 && c < 40) begin step(1); c++; end
      vectors++; if (c != 10 || hb_bus.tx_data !== 56'hA5_21_000000_00_84) begin miscompares++; $display("FAIL hb_period: got cycles=%0d data=%h expected 10 a5210000000084", c, hb_bus.tx_data); end
   endtask

   task automatic test_run_off();
      run_h = 1'b0; hb_bus.tx_ready = 1'b0;
      step(3);
      vectors++; if (hb_bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL run_drop_send: got valid=%b expected 1", hb_bus.tx_valid); end
      hb_bus.tx_ready = 1'b1;
      step(1);
      for (int k = 0; k < 5; k++) begin
         ecg_data_h = 24'h00AA00 + 24'(k); ecg_valid_h = 1'b1; step(1);
         vectors++; if (ecg_ack_h !== 1'b1 || hb_bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL run_off_%0d: got ack=%b valid=%b expected 1 0", k, ecg_ack_h, hb_bus.tx_valid); end
         ecg_valid_h = 1'b0; step(4);
      end
      vectors++; if (ovr_cnt_h !== 8'h00 || busy_h !== 1'b0 || hb_bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL run_off_idle: got ovr=%h busy=%b valid=%b expected 00 0 0", ovr_cnt_h, busy_h, hb_bus.tx_valid); end
   endtask

   task automatic test_saturation();
      ecg_data = 24'h0A0B0C; ecg_valid = 1'b1; step(1);
      ecg_valid = 1'b0; step(1);
      ecg_data = 24'hDEAD00; ecg_valid = 1'b1; step(1);
      vectors++; if (ovr_cnt !== 8'h01) begin miscompares++; $display("FAIL grant_cycle_discard: got %h expected 01", ovr_cnt); end
      ecg_valid = 1'b0; step(1);
      ecg_valid = 1'b1; step(1);
      ecg_valid = 1'b0; step(1);
      vectors++; if (ovr_cnt !== 8'h01 || busy !== 1'b1) begin miscompares++; $display("FAIL post_grant_capture: got ovr=%h busy=%b expected 01 1", ovr_cnt, busy); end
      for (int k = 0; k < 260; k++) begin
         ecg_valid = 1'b1; step(1); ecg_valid = 1'b0; step(1);
      end
      vectors++; if (ovr_cnt !== 8'hFF) begin miscompares++; $display("FAIL overrun_saturate: got %h expected ff", ovr_cnt); end
      vectors++; if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== 56'hA5_12_0A0B0C_00_BA) begin miscompares++; $display("FAIL sat_held_frame: got valid=%b data=%h expected 1 a5120a0b0c00ba", tx_bus.tx_valid, tx_bus.tx_data); end
   endtask

   task automatic test_reset_in_send();
      logic [55:0] d;
      bit ok;
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (tx_bus.tx_valid !== 1'b0 || ovr_cnt !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL async_reset: got valid=%b ovr=%h busy=%b expected 0 00 0", tx_bus.tx_valid, ovr_cnt, busy); end
      touch_status = 12'h000;
      step(1);
      rst_n = 1'b1; ecg_data = 24'h000001; ecg_valid = 1'b1;
      step(1);
      ecg_valid = 1'b0;
      take_frame(d, ok);
      vectors++; if (!ok || d !== 56'hA5_10_000001_00_B4) begin miscompares++; $display("FAIL post_reset_frame: got ok=%b data=%h expected a51000000100b4", ok, d); end
   endtask

   initial begin
      test_reset();
      test_ecg_frame();
      test_touch_frame();
      test_overrun();
      test_round_robin();
      test_heartbeat();
      test_run_off();
      test_saturation();
      test_reset_in_send();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
